connect4_turn_ctrl: RTL and testbench

Game sequencer for the Connect-4 datapath. It debounces the player push-button and issues single-cycle placement commands with column and colour to the piece-placement block. It waits for that block's valid-move acknowledge, then checks the 42-bit player bitboards for a win or draw and alternates turns. It sits between the board I/O (button, switches) and the placement block, and drives debug LEDs and the winner indication to the VGA renderer.

---
 rtl/connect4_turn_ctrl_if.sv | 27 ++
 rtl/connect4_turn_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_connect4_turn_ctrl.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/connect4_turn_ctrl_if.sv
// Bundle of signals between the Connect-4 turn sequencer, the board I/O and the placement block.
// master = sequencer side, slave = board/placement/renderer side.
interface connect4_turn_ctrl_if;
  logic        place_btn;
  logic [2:0]  col_sel;
  logic [41:0] red_player;
  logic [41:0] yellow_player;
  logic        valid_move;
  logic        place_en;
  logic        is_red;
  logic [2:0]  col_out;
  logic        board_clear;
  logic        bad_move;
  logic        game_over;
  logic [1:0]  winner;
  logic [2:0]  state_dbg;

  modport master (
    input  place_btn, col_sel, red_player, yellow_player, valid_move,
    output place_en, is_red, col_out, board_clear, bad_move, game_over, winner, state_dbg
  );

  modport slave (
    output place_btn, col_sel, red_player, yellow_player, valid_move,
    input  place_en, is_red, col_out, board_clear, bad_move, game_over, winner, state_dbg
  );
endinterface

// File: rtl/connect4_turn_ctrl.sv
// Connect-4 game sequencer: debounced button -> placement strobe -> acknowledge wait ->
// win/draw check -> turn hand-over, with per-turn time limit and restart handling.
module connect4_turn_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned RESP_CYCLES     = 4,
  parameter int unsigned TURN_CYCLES     = 250000000
) (
  input  logic                  clk,
  input  logic                  reset,
  connect4_turn_ctrl_if.master  bus
);

  typedef enum logic [2:0] {
    StReady    = 3'd0,
    StIssue    = 3'd1,
    StWaitAck  = 3'd2,
    StSettle   = 3'd3,
    StCheck    = 3'd4,
    StGameOver = 3'd5
  } state_e;

  localparam bit          TimerEn  = (TURN_CYCLES != 0);
  localparam logic [31:0] TurnLoad = TimerEn ? 32'(TURN_CYCLES - 1) : 32'd0;

  state_e      state_q;
  logic [1:0]  sync_q;
  logic        db_level_q;
  logic        db_prev_q;
  logic [31:0] db_cnt_q;
  logic [31:0] turn_cnt_q;
  logic [31:0] ack_cnt_q;
  logic        is_red_q;
  logic        place_en_q;
  logic [2:0]  col_q;
  logic        board_clear_q;
  logic        bad_move_q;
  logic        game_over_q;
  logic [1:0]  winner_q;

  logic        press;
  logic        expired;
  logic [41:0] mover_board;
  logic        win;
  logic        full;

  // Scan all 69 four-windows: horizontal, vertical and both diagonals.
  function automatic logic four_in_row(input logic [41:0] b);
    logic hit;
    hit = 1'b0;
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 7; c++) begin
        if (c <= 3) hit = hit | (b[r*7+c] & b[r*7+c+1] & b[r*7+c+2] & b[r*7+c+3]);
        if (r <= 2) hit = hit | (b[r*7+c] & b[r*7+c+7] & b[r*7+c+14] & b[r*7+c+21]);
        if (r <= 2 && c <= 3)
          hit = hit | (b[r*7+c] & b[r*7+c+8] & b[r*7+c+16] & b[r*7+c+24]);
        if (r <= 2 && c >= 3)
          hit = hit | (b[r*7+c] & b[r*7+c+6] & b[r*7+c+12] & b[r*7+c+18]);
      end
    end
    return hit;
  endfunction

  assign press   = db_level_q & ~db_prev_q;
  assign expired = TimerEn && (turn_cnt_q == 32'd0);

  always_comb begin
    mover_board = is_red_q ? bus.red_player : bus.yellow_player;
    win         = four_in_row(mover_board);
    full        = &(bus.red_player | bus.yellow_player);
  end

  // Level changes only after the synchronized input has disagreed for a full window.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q     <= 2'b00;
      db_level_q <= 1'b0;
      db_prev_q  <= 1'b0;
      db_cnt_q   <= 32'd0;
    end else begin
      sync_q    <= {sync_q[0], bus.place_btn};
      db_prev_q <= db_level_q;
      if (sync_q[1] != db_level_q) begin
        if (db_cnt_q + 32'd1 >= DEBOUNCE_CYCLES) begin
          db_level_q <= sync_q[1];
          db_cnt_q   <= 32'd0;
        end else begin
          db_cnt_q <= db_cnt_q + 32'd1;
        end
      end else begin
        db_cnt_q <= 32'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StReady;
      is_red_q      <= 1'b1;
      place_en_q    <= 1'b0;
      col_q         <= 3'd0;
      board_clear_q <= 1'b0;
      bad_move_q    <= 1'b0;
      game_over_q   <= 1'b0;
      winner_q      <= 2'b00;
      turn_cnt_q    <= TurnLoad;
      ack_cnt_q     <= 32'd0;
    end else begin
      place_en_q    <= 1'b0;
      board_clear_q <= 1'b0;
      bad_move_q    <= 1'b0;
      unique case (state_q)
        StReady: begin
          if (press) begin
            if (bus.col_sel != 3'd7) begin
              col_q      <= bus.col_sel;
              place_en_q <= 1'b1;
              state_q    <= StIssue;
            end else begin
              bad_move_q <= 1'b1;
              if (turn_cnt_q != 32'd0) turn_cnt_q <= turn_cnt_q - 32'd1;
            end
          end else if (expired) begin
            bad_move_q <= 1'b1;
            is_red_q   <= ~is_red_q;
            turn_cnt_q <= TurnLoad;
          end else if (turn_cnt_q != 32'd0) begin
            turn_cnt_q <= turn_cnt_q - 32'd1;
          end
        end
        StIssue: begin
          // The strobe cycle counts as the first cycle of the response window.
          ack_cnt_q <= 32'd1;
          state_q   <= StWaitAck;
        end
        StWaitAck: begin
          if (bus.valid_move) begin
            state_q <= StSettle;
          end else if (ack_cnt_q + 32'd1 >= RESP_CYCLES) begin
            bad_move_q <= 1'b1;
            turn_cnt_q <= TurnLoad;
            state_q    <= StReady;
          end else begin
            ack_cnt_q <= ack_cnt_q + 32'd1;
          end
        end
        StSettle: state_q <= StCheck;
        StCheck: begin
          if (win) begin
            winner_q    <= is_red_q ? 2'b01 : 2'b10;
            game_over_q <= 1'b1;
            state_q     <= StGameOver;
          end else if (full) begin
            winner_q    <= 2'b11;
            game_over_q <= 1'b1;
            state_q     <= StGameOver;
          end else begin
            is_red_q   <= ~is_red_q;
            turn_cnt_q <= TurnLoad;
            state_q    <= StReady;
          end
        end
        StGameOver: begin
          if (press) begin
            board_clear_q <= 1'b1;
            winner_q      <= 2'b00;
            game_over_q   <= 1'b0;
            is_red_q      <= 1'b1;
            turn_cnt_q    <= TurnLoad;
            state_q       <= StReady;
          end
        end
        default: state_q <= StReady;
      endcase
    end
  end

  assign bus.place_en    = place_en_q;
  assign bus.is_red      = is_red_q;
  assign bus.col_out     = col_q;
  assign bus.board_clear = board_clear_q;
  assign bus.bad_move    = bad_move_q;
  assign bus.game_over   = game_over_q;
  assign bus.winner      = winner_q;
  assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_connect4_turn_ctrl.sv
// Directed bench for connect4_turn_ctrl: table of single-move board outcomes plus
// hand-written sequences for debounce, rejection, timeout, restart and reset corners.
module tb_connect4_turn_ctrl;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  connect4_turn_ctrl_if bus ();

  connect4_turn_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .RESP_CYCLES    (3),
    .TURN_CYCLES    (100)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit          yellow_turn;
    logic [41:0] red;
    logic [41:0] yel;
    logic [1:0]  exp_winner;
    logic        exp_red;
    logic        exp_over;
  } vec_t;

  vec_t  vecs[11];
  string names[11];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    bus.place_btn     = 1'b0;
    bus.col_sel       = 3'd0;
    bus.red_player    = '0;
    bus.yellow_player = '0;
    bus.valid_move    = 1'b0;
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  // Idle, then hold the button until place_en shows up (bounded); counts bad_move pulses seen.
  task automatic press(input logic [2:0] col, output bit seen, output int bads);
    seen = 1'b0;
    bads = 0;
    repeat (10) step();
    bus.col_sel   = col;
    bus.place_btn = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (bus.place_en) seen = 1'b1;
      if (bus.bad_move) bads++;
    end
    bus.place_btn = 1'b0;
  endtask

  // Full accepted move; returns in the cycle after CHECK has resolved.
  task automatic turn(input logic [41:0] red, input logic [41:0] yel, input string name);
    bit seen;
    int bads;
    press(3'd0, seen, bads);
    chk({name, "_place_en"}, 64'(seen), 64'd1);
    step();
    bus.valid_move    = 1'b1;
    bus.red_player    = red;
    bus.yellow_player = yel;
    step();
    bus.valid_move = 1'b0;
    step();
    step();
  endtask

  function automatic logic [41:0] draw_board();
    logic [41:0] b;
    b = '0;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 7; c++)
        b[r*7+c] = (((r / 2) + c) % 2) == 0;
    return b;
  endfunction

  function automatic logic [41:0] bits4(input int a, input int b, input int c, input int d);
    logic [41:0] v;
    v = '0;
    v[a] = 1'b1;
    v[b] = 1'b1;
    v[c] = 1'b1;
    v[d] = 1'b1;
    return v;
  endfunction

  initial begin
    logic [41:0] dr;
    logic [41:0] fw;
    logic [41:0] one;
    bit          seen;
    int          bads;
    int          n;
    int          pulses;
    logic [2:0]  col_at_pulse;

    checks   = 0;
    failures = 0;
    dr  = draw_board();
    fw  = dr | bits4(14, 21, 0, 7);
    one = '0;
    one[2] = 1'b1;

    names[0]  = "no_win";      vecs[0]  = '{0, one, '0, 2'b00, 1'b0, 1'b0};
    names[1]  = "vert_red";    vecs[1]  = '{0, bits4(0, 7, 14, 21), '0, 2'b01, 1'b1, 1'b1};
    names[2]  = "horiz_red";   vecs[2]  = '{0, bits4(7, 8, 9, 10), '0, 2'b01, 1'b1, 1'b1};
    names[3]  = "diag_ur";     vecs[3]  = '{0, bits4(0, 8, 16, 24), '0, 2'b01, 1'b1, 1'b1};
    names[4]  = "diag_ul";     vecs[4]  = '{0, bits4(3, 9, 15, 21), '0, 2'b01, 1'b1, 1'b1};
    names[5]  = "row_wrap";    vecs[5]  = '{0, bits4(4, 5, 6, 7), '0, 2'b00, 1'b0, 1'b0};
    names[6]  = "yel_only";    vecs[6]  = '{0, one, bits4(0, 7, 14, 21), 2'b00, 1'b0, 1'b0};
    names[7]  = "yel_vert";    vecs[7]  = '{1, one, bits4(20, 27, 34, 41), 2'b10, 1'b0, 1'b1};
    names[8]  = "draw";        vecs[8]  = '{0, dr, ~dr, 2'b11, 1'b1, 1'b1};
    names[9]  = "full_win";    vecs[9]  = '{0, fw, ~fw, 2'b01, 1'b1, 1'b1};
    names[10] = "diag_corner"; vecs[10] = '{0, bits4(17, 25, 33, 41), '0, 2'b01, 1'b1, 1'b1};

    // Reset state
    do_reset();
    chk("rst_state", 64'(bus.state_dbg), 64'd0);
    chk("rst_is_red", 64'(bus.is_red), 64'd1);
    chk("rst_place_en", 64'(bus.place_en), 64'd0);
    chk("rst_col_out", 64'(bus.col_out), 64'd0);
    chk("rst_winner", 64'(bus.winner), 64'd0);
    chk("rst_game_over", 64'(bus.game_over), 64'd0);
    chk("rst_bad_move", 64'(bus.bad_move), 64'd0);
    chk("rst_board_clear", 64'(bus.board_clear), 64'd0);

    // Bounce: toggling every 2 cycles never passes the filter; a steady hold gives one event
    bus.col_sel  = 3'd3;
    pulses       = 0;
    col_at_pulse = 3'd0;
    for (int i = 0; i < 20; i++) begin
      bus.place_btn = ((i / 2) % 2) == 0;
      step();
      if (bus.place_en) pulses++;
    end
    chk("bounce_no_event", 64'(pulses), 64'd0);
    bus.place_btn = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step();
      if (bus.place_en) begin
        pulses++;
        col_at_pulse = bus.col_out;
      end
    end
    bus.place_btn = 1'b0;
    chk("bounce_one_pulse", 64'(pulses), 64'd1);
    chk("bounce_col_out", 64'(col_at_pulse), 64'd3);
    chk("bounce_is_red", 64'(bus.is_red), 64'd1);

    // Normal turn: valid_move one cycle after place_en
    do_reset();
    press(3'd2, seen, bads);
    chk("normal_place_en", 64'(seen), 64'd1);
    chk("normal_col_out", 64'(bus.col_out), 64'd2);
    step();
    bus.valid_move = 1'b1;
    step();
    bus.valid_move = 1'b0;
    chk("normal_is_red_settle", 64'(bus.is_red), 64'd1);
    step();
    chk("normal_is_red_check", 64'(bus.is_red), 64'd1);
    step();
    chk("normal_is_red_switch", 64'(bus.is_red), 64'd0);
    chk("normal_winner", 64'(bus.winner), 64'd0);
    chk("normal_state", 64'(bus.state_dbg), 64'd0);

    // Rejected move: no acknowledge
    do_reset();
    press(3'd5, seen, bads);
    chk("reject_place_en", 64'(seen), 64'd1);
    step();
    chk("reject_bad_t1", 64'(bus.bad_move), 64'd0);
    step();
    chk("reject_bad_t2", 64'(bus.bad_move), 64'd0);
    step();
    chk("reject_bad_t3", 64'(bus.bad_move), 64'd1);
    chk("reject_state", 64'(bus.state_dbg), 64'd0);
    chk("reject_is_red", 64'(bus.is_red), 64'd1);
    bus.valid_move = 1'b1;
    step();
    bus.valid_move = 1'b0;
    chk("reject_bad_t4", 64'(bus.bad_move), 64'd0);
    repeat (4) step();
    chk("stray_ack_state", 64'(bus.state_dbg), 64'd0);
    chk("stray_ack_is_red", 64'(bus.is_red), 64'd1);

    // Table-driven single-move outcomes
    for (int v = 0; v < 11; v++) begin
      do_reset();
      if (vecs[v].yellow_turn) turn('0, '0, {names[v], "_pre"});
      turn(vecs[v].red, vecs[v].yel, names[v]);
      chk({names[v], "_winner"}, 64'(bus.winner), 64'(vecs[v].exp_winner));
      chk({names[v], "_is_red"}, 64'(bus.is_red), 64'(vecs[v].exp_red));
      chk({names[v], "_game_over"}, 64'(bus.game_over), 64'(vecs[v].exp_over));
      chk({names[v], "_state"}, 64'(bus.state_dbg), vecs[v].exp_over ? 64'd5 : 64'd0);
    end

    // Win, frozen timer in GAME_OVER, then restart
    do_reset();
    turn(bits4(0, 7, 14, 21), '0, "restart_win");
    chk("restart_winner", 64'(bus.winner), 64'd1);
    bads = 0;
    for (int i = 0; i < 150; i++) begin
      step();
      if (bus.bad_move) bads++;
    end
    chk("over_no_timeout", 64'(bads), 64'd0);
    chk("over_state_held", 64'(bus.state_dbg), 64'd5);
    bus.red_player = '0;
    bus.col_sel    = 3'd1;
    bus.place_btn  = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (bus.board_clear) seen = 1'b1;
    end
    bus.place_btn = 1'b0;
    chk("restart_board_clear", 64'(seen), 64'd1);
    chk("restart_winner_clr", 64'(bus.winner), 64'd0);
    chk("restart_game_over", 64'(bus.game_over), 64'd0);
    chk("restart_is_red", 64'(bus.is_red), 64'd1);
    chk("restart_state", 64'(bus.state_dbg), 64'd0);
    step();
    chk("restart_clear_pulse", 64'(bus.board_clear), 64'd0);
    chk("restart_no_place", 64'(bus.place_en), 64'd0);

    // Turn timeout, then illegal column
    do_reset();
    n = 0;
    for (int i = 0; i < 200 && !bus.bad_move; i++) begin
      step();
      n++;
    end
    chk("timeout_cycles", 64'(n), 64'd100);
    chk("timeout_is_red", 64'(bus.is_red), 64'd0);
    press(3'd7, seen, bads);
    chk("illegal_no_place", 64'(seen), 64'd0);
    chk("illegal_bad_pulses", 64'(bads), 64'd1);
    chk("illegal_is_red", 64'(bus.is_red), 64'd0);
    chk("illegal_state", 64'(bus.state_dbg), 64'd0);

    // Async reset while the strobe is out; a later acknowledge must be ignored
    do_reset();
    press(3'd4, seen, bads);
    chk("midrst_place_en", 64'(seen), 64'd1);
    reset = 1'b0;
    #1;
    chk("midrst_place_drop", 64'(bus.place_en), 64'd0);
    chk("midrst_state", 64'(bus.state_dbg), 64'd0);
    bus.valid_move = 1'b1;
    step();
    reset = 1'b1;
    step();
    bus.valid_move = 1'b0;
    repeat (3) step();
    chk("midrst_ack_ignored", 64'(bus.state_dbg), 64'd0);
    chk("midrst_is_red", 64'(bus.is_red), 64'd1);
    chk("midrst_col_out", 64'(bus.col_out), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
